// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Clears instruction memory, streams a program into it over a
//                valid/ready handshake, verifies a trailing checksum word and
//                releases the CPU only once the image is proven good.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int SIZE       = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load_valid,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic                    load_last,
    output logic                    load_ready,
    output logic                    mem_we,
    output logic [31:0]             mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    busy,
    output logic                    cpu_run,
    output logic                    done,
    output logic                    error,
    output logic [$clog2(SIZE):0]   word_count
);

    localparam int                 c_CNT_W = $clog2(SIZE) + 1;
    localparam logic [c_CNT_W-1:0] c_SIZE  = c_CNT_W'(SIZE);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;
    localparam logic [2:0] c_RUN   = 3'd4;
    localparam logic [2:0] c_ERROR = 3'd5;

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_clr_idx;
    logic [c_CNT_W-1:0]    r_word_count;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_load_ready;
    logic                  r_mem_we;
    logic [31:0]           r_mem_waddr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;
    logic                  r_cpu_run;
    logic                  r_done;
    logic                  r_error;

    logic                  w_accept;
    logic [31:0]           w_clr_addr;
    logic [31:0]           w_word_addr;

    assign w_accept    = load_valid & r_load_ready;
    assign w_clr_addr  = 32'(r_clr_idx) << 2;
    assign w_word_addr = 32'(r_word_count) << 2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_clr_idx    <= '0;
            r_word_count <= '0;
            r_sum        <= '0;
            r_load_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_IDLE, c_RUN, c_ERROR: begin
                    if (start) begin
                        // First clear write (address 0) is issued straight away
                        r_state      <= c_CLEAR;
                        r_mem_we     <= 1'b1;
                        r_mem_waddr  <= '0;
                        r_mem_wdata  <= '0;
                        r_clr_idx    <= c_CNT_W'(1);
                        r_sum        <= '0;
                        r_word_count <= '0;
                        r_load_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_cpu_run    <= 1'b0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end

                c_CLEAR: begin
                    if (r_clr_idx == c_SIZE) begin
                        r_state      <= c_LOAD;
                        r_load_ready <= 1'b1;
                    end else begin
                        r_mem_we    <= 1'b1;
                        r_mem_waddr <= w_clr_addr;
                        r_mem_wdata <= '0;
                        r_clr_idx   <= r_clr_idx + 1'b1;
                    end
                end

                c_LOAD: begin
                    if (w_accept) begin
                        if (r_word_count == c_SIZE) begin
                            // Image larger than memory: drop the beat
                            r_state      <= c_ERROR;
                            r_load_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_mem_we     <= 1'b1;
                            r_mem_waddr  <= w_word_addr;
                            r_mem_wdata  <= load_data;
                            r_word_count <= r_word_count + 1'b1;
                            r_sum        <= r_sum + load_data;
                            if (load_last) begin
                                r_state <= c_CHECK;
                            end
                        end
                    end
                end

                c_CHECK: begin
                    if (w_accept) begin
                        r_load_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        if (load_data == r_sum) begin
                            r_state   <= c_RUN;
                            r_cpu_run <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= c_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= c_IDLE;
                    r_load_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cpu_run    <= 1'b0;
                    r_done       <= 1'b0;
                    r_error      <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign mem_we     = r_mem_we;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign cpu_run    = r_cpu_run;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Scoreboard bench for imem_boot_loader; expected memory writes
//                are queued as stimulus is driven and popped on each write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int SIZE = 32;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          mem_we;
    logic [31:0]   mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          cpu_run;
    logic          done;
    logic          error;
    logic [5:0]    word_count;

    int            errors = 0;
    int            checks = 0;
    logic [63:0]   sb_q[$];
    logic [63:0]   mon_exp;
    int            exp_n;
    logic [31:0]   exp_sum;

    imem_boot_loader #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_run    (cpu_run),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected", mem_waddr, mem_wdata);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({mem_waddr, mem_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_write got addr=%h data=%h expected addr=%h data=%h",
                             mem_waddr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        for (int i = 0; i < SIZE; i++) sb_q.push_back({32'(i * 4), 32'h0});
        exp_n   = 0;
        exp_sum = 32'h0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_clear();
        repeat (SIZE) tick();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit acc;
        acc        = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = load_ready;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL beat_timeout data=%h never accepted, load_ready=%b", d, load_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        sb_q.push_back({32'(exp_n * 4), d});
        exp_n++;
        exp_sum = exp_sum + d;
        send_beat(d, l);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        repeat (2) tick();
        checks++;
        if ({mem_we, load_ready, busy, cpu_run, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000", {mem_we, load_ready, busy, cpu_run, done, error});
        end
        checks++;
        if ({word_count, mem_waddr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got wc=%0d addr=%h data=%h expected zeros", word_count, mem_waddr, mem_wdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pulse_start();
        checks++;
        if ({busy, load_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_clear_entry got busy,ready=%b expected 10", {busy, load_ready});
        end
        repeat (SIZE - 1) tick();
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_early got %b expected 0 in last clear cycle", load_ready);
        end
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_start got %b expected 1", load_ready);
        end
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b1);
        checks++;
        if ({load_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL basic_check_ready got ready,busy=%b expected 11", {load_ready, busy});
        end
        send_beat(32'h6, 1'b0);
        checks++;
        if ({cpu_run, done, busy, load_ready, error} !== 5'b11000) begin
            errors++;
            $display("FAIL basic_run got run,done,busy,ready,err=%b expected 11000",
                     {cpu_run, done, busy, load_ready, error});
        end
        checks++;
        if (word_count !== 6'd3) begin
            errors++;
            $display("FAIL basic_word_count got %0d expected 3", word_count);
        end
        load_valid = 1'b1; load_data = 32'hDEAD_BEEF; load_last = 1'b1;
        repeat (3) tick();
        load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if ({cpu_run, done} !== 2'b11) begin
            errors++;
            $display("FAIL run_ignores_beats got run,done=%b expected 11", {cpu_run, done});
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing_writes got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        checks++;
        if ({cpu_run, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL restart_from_run got run,done,busy=%b expected 001", {cpu_run, done, busy});
        end
        wait_clear();
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b1);
        send_beat(32'h7, 1'b0);
        checks++;
        if ({error, cpu_run, done, load_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_checksum got err,run,done,ready=%b expected 1000",
                     {error, cpu_run, done, load_ready});
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL bad_missing_writes got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_wrap();
        pulse_start();
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL restart_from_error got err,busy=%b expected 01", {error, busy});
        end
        wait_clear();
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0002, 1'b1);
        send_beat(32'h0000_0001, 1'b0);
        checks++;
        if ({cpu_run, done, error} !== 3'b110) begin
            errors++;
            $display("FAIL wrap_sum got run,done,err=%b expected 110", {cpu_run, done, error});
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        wait_clear();
        for (int i = 0; i < SIZE; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
        send_beat(32'h0000_0BAD, 1'b0);
        checks++;
        if ({error, cpu_run, busy, load_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL overflow_state got err,run,busy,ready=%b expected 1000",
                     {error, cpu_run, busy, load_ready});
        end
        checks++;
        if (word_count !== 6'd32) begin
            errors++;
            $display("FAIL overflow_count got %0d expected 32", word_count);
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_missing_writes got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        pulse_start();
        wait_clear();
        send_word(32'h10, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, load_ready, mem_we, word_count} !== {3'b110, 6'd1}) begin
            errors++;
            $display("FAIL start_in_load got busy,ready,we=%b wc=%0d expected 110 wc=1",
                     {busy, load_ready, mem_we}, word_count);
        end
        send_word(32'h20, 1'b0);
        tick();
        send_word(32'h30, 1'b1);
        tick();
        send_beat(32'h60, 1'b0);
        checks++;
        if ({cpu_run, word_count} !== {1'b1, 6'd3}) begin
            errors++;
            $display("FAIL backpressure_run got run=%b wc=%0d expected run=1 wc=3", cpu_run, word_count);
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_missing_writes got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        wait_clear();
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_we, load_ready, busy, cpu_run, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b wc=%0d expected all 0",
                     {mem_we, load_ready, busy, cpu_run, done, error}, word_count);
        end
        reset = 1'b1;
        tick();
        pulse_start();
        wait_clear();
        send_word(32'h55, 1'b1);
        send_beat(32'h55, 1'b0);
        checks++;
        if ({cpu_run, done, error, word_count} !== {3'b110, 6'd1}) begin
            errors++;
            $display("FAIL reload_after_reset got run,done,err=%b wc=%0d expected 110 wc=1",
                     {cpu_run, done, error}, word_count);
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL reload_missing_writes got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_wrap();
        test_overflow();
        test_backpressure();
        test_reset_mid_load();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller that owns the instruction memory write port. After a start pulse it clears every instruction word, streams a program into memory over a valid/ready handshake, and verifies a trailing checksum word. It holds the pipeline in reset until the image is proven good. It sits between the off-chip/testbench program source and the instruction memory, and gates the CPU's run enable.

## Interface
- size, 32: instruction memory depth in 32-bit words.
- data_width, 32: instruction word width.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on clk.
- start  in  1  one-cycle pulse; begins clear+load from IDLE, RUN or ERROR.
- load_valid  in  1  source presents load_data this cycle.
- load_data  in  data_width  program word, or checksum word in CHECK.
- load_last  in  1  marks final program word; ignored in CHECK.
- load_ready  out  1  loader accepts a beat this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_waddr  out  32  byte address; always word-aligned (4*index).
- mem_wdata  out  data_width  write data.
- busy  out  1  state is CLEAR, LOAD or CHECK.
- cpu_run  out  1  releases pipeline; 1 only in RUN.
- done  out  1  image loaded and verified; 1 only in RUN.
- error  out  1  1 only in ERROR.
- word_count  out  $clog2(size)+1  program words written so far.

## Operation
- States: IDLE, CLEAR, LOAD, CHECK, RUN, ERROR. All outputs are registered.
- Reset (reset=0 at an edge): state IDLE. All outputs 0, clear index 0, word_count 0, running sum 0. Reset aborts any state. Memory is left with partial contents. cpu_run is 0 from the next cycle.
- IDLE: on start, go to CLEAR.
- CLEAR: one write per cycle, mem_we=1, mem_wdata=0, mem_waddr=0,4,…,4*(size-1). Exactly size cycles, then LOAD. Clears sum and word_count.
- LOAD:
  - load_ready=1. A beat is accepted when load_valid & load_ready at an edge.
  - For accepted word n (0-based), the next cycle drives mem_we=1, mem_waddr=4*n, mem_wdata=word.
  - word_count increments. sum ← sum + word, modulo 2^32, carry discarded.
  - If load_last is set on an accepted word, go to CHECK.
  - If a beat is accepted while word_count==size, go to ERROR. That word is not written.
- CHECK:
  - load_ready=1, mem_we=0.
  - Accepted word equals sum: go to RUN.
  - Otherwise: go to ERROR.
- RUN: cpu_run=1, done=1, load_ready=0. Beats on load_* are ignored.
- ERROR: error=1, cpu_run=0, load_ready=0.
- start in RUN or ERROR goes to CLEAR. cpu_run, done and error drop the next cycle.
- start in CLEAR, LOAD or CHECK is ignored.
- load_valid with load_ready=0 is ignored. The source must hold load_data until accepted.

## Timing
- start sampled at edge 0: CLEAR during cycles 1..size. load_ready=1 from cycle size+1.
- Accept-to-write latency: 1 cycle. A beat accepted every cycle gives back-to-back writes with no bubbles.
- Last program word accepted at edge k: CHECK from cycle k+1, load_ready stays 1 with no gap.
- Checksum accepted at edge j: cpu_run=1 and done=1 (or error=1) from cycle j+1.
- Minimum load time for N words with continuous valid: size + N + 2 cycles from start to cpu_run.
- Reset has priority over start and over handshakes in the same cycle.

## Test plan
- Basic load (size=32): start, then words 0x00000001, 0x00000002, 0x00000003 (last on third), then checksum 0x00000006.
  - Required: 32 zero writes at 0..124.
  - Required: writes at 0/4/8 with those data.
  - Required: word_count=3, cpu_run=1 and done=1 one cycle after checksum.
- Bad checksum: same program with checksum 0x00000007 -> error=1, cpu_run=0, done=0, load_ready=0.
- Wrap-around sum: words 0xFFFFFFFF, 0x00000002 (last), checksum 0x00000001 -> RUN.
- Overflow: 33 words with no load_last -> 32 writes (addr 0..124). 33rd beat is not written, error=1 next cycle.
- Backpressure and restart:
  - Required: load_valid toggling 1/0 still writes each word exactly once.
  - Required: start during LOAD is ignored.
  - Required: start in RUN drops cpu_run next cycle and re-enters CLEAR.
- Reset mid-LOAD: reset=0 after 2 accepted words.
  - Required: next cycle all outputs 0, state IDLE.
  - Required: a later start performs a full clear and load correctly.
